// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcode map, FSM states, opcode width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOT   = 4'd5,
      OP_SHL1  = 4'd6,
      OP_SHR1  = 4'd7,
      OP_ADC   = 4'd8,
      OP_SBB   = 4'd9,
      OP_SRA1  = 4'd10,
      OP_ROL1  = 4'd11,
      OP_ROR1  = 4'd12,
      OP_MUL   = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one bit of b per cycle.
// Latency: start edge plus WIDTH step cycles; done is high during the last step.
// Backpressure: none; the caller pulses start only when idle.
// Ports: clk, rst (async, active-high), start (loads a/b),
//        a, b (operands) -> done (final step this cycle), prod (2*WIDTH product).
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand;
   // Upper half accumulates partial sums; lower half holds the multiplier
   // bits not yet consumed, shifted out one per step.
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH:0]     sum;
   logic [CNT_W-1:0]   cnt;

   always_comb begin
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      acc_nxt = {sum, acc[WIDTH-1:1]};
   end

   // prod is the post-step value so the caller can capture it on the
   // same edge as the final step, keeping BUSY at exactly WIDTH cycles.
   assign done = (cnt == CNT_W'(1));
   assign prod = acc_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (start) begin
         mcand <= a;
         acc   <= {{WIDTH{1'b0}}, b};
         cnt   <= CNT_W'(WIDTH);
      end else if (cnt != '0) begin
         acc <= acc_nxt;
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, full C/Z/N/V flags, optional iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for MUL (macro ALU_SEQ_MUL_EN).
// Backpressure: result held in RESP until out_ready; in_ready low outside IDLE.
// Ports: clk, rst (async, active-high); in_valid/in_ready, a, b, op, cin (issue side);
//        out_valid/out_ready, y, y_hi, carry, zero, neg, ovf, err (result side).
// Without ALU_SEQ_MUL_EN, op 13 is reported as illegal and no multiplier is built.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err
);

   localparam int MSB = WIDTH - 1;

   state_e state, state_nxt;
   logic   accept;
   logic   is_mul;

   logic [WIDTH-1:0] alu_y;
   logic [WIDTH:0]   ext;
   logic             alu_c, alu_v, alu_err;

   assign accept = in_valid & in_ready;

`ifdef ALU_SEQ_MUL_EN
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign is_mul    = (op == OP_MUL);
   assign mul_start = accept & is_mul;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst   (rst),
      .start (mul_start),
      .a     (a),
      .b     (b),
      .done  (mul_done),
      .prod  (mul_prod)
   );
`else
   assign is_mul = 1'b0;
`endif

   // Single-cycle datapath; evaluated straight off the inputs in the accept cycle.
   always_comb begin
      alu_y   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      ext     = '0;
      case (op_e'(op))
         OP_ADD, OP_ADC: begin
            ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
            alu_y = ext[MSB:0];
            alu_c = ext[WIDTH];
            alu_v = (a[MSB] == b[MSB]) && (alu_y[MSB] != a[MSB]);
         end
         OP_SUB, OP_SBB: begin
            // Top bit of the WIDTH+1 difference is the borrow.
            ext   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (op == OP_SBB) & cin};
            alu_y = ext[MSB:0];
            alu_c = ext[WIDTH];
            alu_v = (a[MSB] != b[MSB]) && (alu_y[MSB] != a[MSB]);
         end
         OP_AND:  alu_y = a & b;
         OP_OR:   alu_y = a | b;
         OP_XOR:  alu_y = a ^ b;
         OP_NOT:  alu_y = ~a;
         OP_SHL1: begin alu_y = {a[MSB-1:0], 1'b0};   alu_c = a[MSB]; end
         OP_SHR1: begin alu_y = {1'b0, a[MSB:1]};     alu_c = a[0];   end
         OP_SRA1: begin alu_y = {a[MSB], a[MSB:1]};   alu_c = a[0];   end
         OP_ROL1: begin alu_y = {a[MSB-1:0], a[MSB]}; alu_c = a[MSB]; end
         OP_ROR1: begin alu_y = {a[0], a[MSB:1]};     alu_c = a[0];   end
`ifdef ALU_SEQ_MUL_EN
         OP_MUL:  ;
`endif
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = is_mul ? BUSY : RESP;
`ifdef ALU_SEQ_MUL_EN
         BUSY: if (mul_done) state_nxt = RESP;
`endif
         RESP: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == RESP);
   end

   // Result registers: written only on accept or on MUL completion, so they
   // stay stable for as long as RESP is backpressured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y     <= '0;
         y_hi  <= '0;
         carry <= 1'b0;
         zero  <= 1'b0;
         neg   <= 1'b0;
         ovf   <= 1'b0;
         err   <= 1'b0;
      end else if (accept && !is_mul) begin
         y     <= alu_y;
         y_hi  <= '0;
         carry <= alu_c;
         zero  <= ~alu_err & (alu_y == '0);
         neg   <= alu_y[MSB];
         ovf   <= alu_v;
         err   <= alu_err;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state == BUSY && mul_done) begin
         y     <= mul_prod[MSB:0];
         y_hi  <= mul_prod[2*WIDTH-1:WIDTH];
         carry <= |mul_prod[2*WIDTH-1:WIDTH];
         zero  <= (mul_prod == '0);
         neg   <= mul_prod[MSB];
         ovf   <= 1'b0;
         err   <= 1'b0;
      end
`endif
   end

endmodule
